// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives the data-memory request/ready handshake,
// flags misaligned accesses and doubles as the MEM/WB pipeline register.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  input  logic        regwrite_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic [1:0]  wb_a,
  output logic [2:0]  wb_readbe,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        wb_adel,
  output logic        wb_ades
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        wb_valid_q, wb_regwrite_q, wb_adel_q, wb_ades_q;
  logic        wb_valid_d, wb_regwrite_d, wb_adel_d, wb_ades_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [1:0]  wb_a_q, wb_a_d;
  logic [2:0]  wb_readbe_q, wb_readbe_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic is_byte, is_half, access, misal, aligned;

  function automatic logic [3:0] store_be(input logic byte_acc, input logic half_acc,
                                          input logic [1:0] a);
    if (byte_acc)      return 4'b0001 << a;
    else if (half_acc) return a[1] ? 4'b1100 : 4'b0011;
    else               return 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic byte_acc, input logic half_acc,
                                             input logic [31:0] d);
    if (byte_acc)      return {4{d[7:0]}};
    else if (half_acc) return {2{d[15:0]}};
    else               return d;
  endfunction

  // Reserved op codes 101-111 fall through to word size.
  assign is_byte = (mem_op == 3'b001) || (mem_op == 3'b010);
  assign is_half = (mem_op == 3'b011) || (mem_op == 3'b100);
  assign access  = mem_valid & (mem_read | mem_write);
  assign misal   = access & ((is_half & addr[0]) |
                             (~is_byte & ~is_half & (addr[1:0] != 2'b00)));
  assign aligned = access & ~misal;
  assign stall   = ((state_q == IDLE) & aligned) | ((state_q == BUSY) & ~bus_ready);

  always_comb begin
    wb_valid_d    = mem_valid;
    wb_rdata_d    = (mem_read & aligned) ? bus_rdata : 32'h0;
    wb_a_d        = addr[1:0];
    wb_readbe_d   = (mem_valid & mem_read) ? mem_op : 3'b000;
    wb_rd_d       = rd_in;
    wb_regwrite_d = mem_valid & regwrite_in & ~misal;
    wb_adel_d     = misal & mem_read;
    wb_ades_d     = misal & mem_write;
    // A held instruction must not retire twice: feed WB a bubble while stalled.
    if (stall) begin
      wb_valid_d    = 1'b0;
      wb_regwrite_d = 1'b0;
      wb_adel_d     = 1'b0;
      wb_ades_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_be_q      <= 4'h0;
      bus_wdata_q   <= 32'h0;
      wb_valid_q    <= 1'b0;
      wb_rdata_q    <= 32'h0;
      wb_a_q        <= 2'b00;
      wb_readbe_q   <= 3'b000;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      wb_adel_q     <= 1'b0;
      wb_ades_q     <= 1'b0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_a_q        <= wb_a_d;
      wb_readbe_q   <= wb_readbe_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_adel_q     <= wb_adel_d;
      wb_ades_q     <= wb_ades_d;
      case (state_q)
        IDLE: begin
          if (aligned) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= mem_write ? store_be(is_byte, is_half, addr[1:0]) : 4'b0000;
            bus_wdata_q <= mem_write ? store_data(is_byte, is_half, wdata) : 32'h0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rdata    = wb_rdata_q;
  assign wb_a        = wb_a_q;
  assign wb_readbe   = wb_readbe_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_adel     = wb_adel_q;
  assign wb_ades     = wb_ades_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed scenarios plus random traffic
// against a byte-addressed memory model with random wait states.
module tb_mem_access_unit;

  logic        clk, reset;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_in;
  logic        regwrite_in;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        stall, wb_valid;
  logic [31:0] wb_rdata;
  logic [1:0]  wb_a;
  logic [2:0]  wb_readbe;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, wb_adel, wb_ades;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .rd_in(rd_in), .regwrite_in(regwrite_in), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_a(wb_a), .wb_readbe(wb_readbe),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_adel(wb_adel), .wb_ades(wb_ades)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  a;
    logic [2:0]  rbe;
    logic [4:0]  rd;
    logic        rw, adel, ades;
    time         t;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  wb_t  wbq[$];
  bus_t busq[$];
  logic [31:0] mem_m [int unsigned];

  int passed = 0;
  int total  = 0;
  int force_wait = -1;
  int wait_cnt = 0;
  int waits_left = 0;
  bit prev_req = 0;
  bit last_ready = 0;
  bus_t cur;
  bus_t snap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: unexpected event at time %0t", name, $time);
  endtask

  function automatic logic [31:0] rd_mem(input logic [29:0] waddr);
    if (mem_m.exists(int'(waddr))) return mem_m[int'(waddr)];
    return {waddr[15:0], ~waddr[15:0]};
  endfunction

  // Bus slave: random wait states, memory update on completion, start/stability checks
  initial begin
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_req && last_ready) begin
        if (cur.we) begin
          logic [31:0] w;
          w = rd_mem(cur.addr[31:2]);
          for (int i = 0; i < 4; i++)
            if (cur.be[i]) w[8*i +: 8] = cur.wdata[8*i +: 8];
          mem_m[int'(cur.addr[31:2])] = w;
        end
        check("req_drop_after_ready", bus_req, 1'b0);
      end
      if (bus_req && !prev_req) begin
        if (busq.size() == 0) fail_now("bus_req_unexpected");
        else begin
          cur = busq.pop_front();
          check("bus_fields", {bus_we, bus_addr, bus_be, bus_wdata},
                {cur.we, cur.addr, cur.be, cur.wdata});
        end
        snap.we = bus_we; snap.addr = bus_addr; snap.be = bus_be; snap.wdata = bus_wdata;
        wait_cnt = 0;
        waits_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      end else if (bus_req && prev_req) begin
        check("bus_stable", {bus_we, bus_addr, bus_be, bus_wdata},
              {snap.we, snap.addr, snap.be, snap.wdata});
      end
      if (bus_req) begin
        if (waits_left > 0) begin
          bus_ready = 1'b0;
          waits_left--;
          wait_cnt++;
        end else begin
          bus_ready = 1'b1;
          bus_rdata = rd_mem(bus_addr[31:2]);
        end
      end else begin
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      prev_req   = bus_req;
      last_ready = bus_ready;
    end
  end

  // WB monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (wbq.size() == 0) fail_now("wb_valid_unexpected");
        else begin
          wb_t e;
          e = wbq.pop_front();
          check("wb_fields",
                {wb_rdata, wb_a, wb_readbe, wb_rd, wb_regwrite, wb_adel, wb_ades},
                {e.rdata, e.a, e.rbe, e.rd, e.rw, e.adel, e.ades});
        end
      end else if (wbq.size() > 0 && wbq[0].t < $time) begin
        void'(wbq.pop_front());
        fail_now("wb_valid_missing");
      end
    end
  end

  // Present one instruction in MEM, hold it while stalled, record expectations.
  task automatic issue(input logic v, input logic r, input logic w, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw);
    int   size;
    bit   acc, mis;
    int   cnt;
    bus_t b;
    wb_t  e;
    size = (op == 3'd1 || op == 3'd2) ? 1 : (op == 3'd3 || op == 3'd4) ? 2 : 4;
    acc  = v && (r || w);
    mis  = acc && ((int'(a[1:0]) % size) != 0);
    mem_valid = v; mem_read = r; mem_write = w; mem_op = op;
    addr = a; wdata = wd; rd_in = rd; regwrite_in = rw;
    if (acc && !mis) begin
      b.we   = w;
      b.addr = a & 32'hFFFF_FFFC;
      if (w) begin
        b.be    = 4'(((1 << size) - 1) << int'(a[1:0]));
        b.wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                  (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      end else begin
        b.be    = 4'h0;
        b.wdata = 32'h0;
      end
      busq.push_back(b);
    end
    @(negedge clk);
    check("stall_first_cycle", stall, 1'(acc && !mis));
    if (acc && !mis) begin
      cnt = 0;
      while (stall === 1'b1 && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      check("stall_cycles", cnt, 1 + wait_cnt);
    end
    if (v) begin
      e.rdata = (acc && !mis && r) ? rd_mem(a[31:2]) : 32'h0;
      e.a     = a[1:0];
      e.rbe   = r ? op : 3'b000;
      e.rd    = rd;
      e.rw    = rw && !mis;
      e.adel  = mis && r;
      e.ades  = mis && w;
      e.t     = $time;
      wbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", wbq.size());
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_valid = 0; mem_read = 0; mem_write = 0; mem_op = 0;
    addr = 0; wdata = 0; rd_in = 0; regwrite_in = 0;
    mem_m[32'h1000 >> 2] = 32'h80AB_CD12;
    #3;
    check("reset_bus", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 0);
    check("reset_wb", {wb_valid, wb_rdata, wb_a, wb_readbe, wb_rd, wb_regwrite, wb_adel, wb_ades}, 0);
    check("reset_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    force_wait = 0;
    issue(1, 1, 0, 3'b010, 32'h1003, 32'h0, 5'd3, 1);          // lb
    issue(1, 0, 1, 3'b011, 32'h2002, 32'h0000_1234, 5'd0, 0);  // sh
    force_wait = 3;
    issue(1, 1, 0, 3'b000, 32'h3000, 32'h0, 5'd7, 1);          // lw, 3 waits
    force_wait = 0;
    issue(1, 1, 0, 3'b000, 32'h3002, 32'h0, 5'd8, 1);          // misaligned lw
    issue(1, 0, 1, 3'b011, 32'h3001, 32'h5555, 5'd0, 0);       // misaligned sh

    // Abort a long transaction with reset
    force_wait = 1000;
    mem_valid = 1; mem_read = 1; mem_write = 0; mem_op = 3'b000;
    addr = 32'h40; rd_in = 5'd9; regwrite_in = 1;
    busq.push_back('{we: 1'b0, addr: 32'h40, be: 4'h0, wdata: 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_reset", bus_req, 1'b1);
    #2;
    reset = 1'b0;
    mem_valid = 0;
    #1;
    check("reset_abort_req", bus_req, 1'b0);
    check("reset_abort_wb", wb_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    force_wait = 0;
    issue(1, 0, 1, 3'b000, 32'h10, 32'hDEAD_BEEF, 5'd0, 0);    // sw after reset
    issue(1, 1, 0, 3'b000, 32'h10, 32'h0, 5'd4, 1);            // read it back

    for (int i = 0; i < 3; i++)
      issue(1, 0, 0, 3'(i), 32'h100 + 32'(i), 32'h0, 5'(i + 10), 1);

    force_wait = -1;
    for (int i = 0; i < 300; i++) begin
      logic v, r, w;
      int kind;
      kind = int'($urandom_range(0, 9));
      v = (kind != 0);
      r = (kind >= 1 && kind <= 4);
      w = (kind >= 5 && kind <= 7);
      issue(v, r, w, 3'($urandom_range(0, 7)), {24'h0, 8'($urandom)}, $urandom,
            5'($urandom), 1'($urandom_range(0, 1)));
    end

    mem_valid = 0;
    repeat (5) @(negedge clk);
    check("wb_queue_drained", wbq.size(), 0);
    check("bus_queue_drained", busq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
